lgn_frame_sequencer: RTL and testbench

- Sequences one classification frame into the logic-gate-network (lgn) datapath.
- Accepts a byte stream from a valid/ready source and drives exactly BYTES_PER_FRAME registered writes into lgn.
- Waits the fixed network latency, captures the lgn output word, and holds it on a valid/ready result port.
- Sits between the pad-level pixel interface and the lgn instance in chip_core. Replaces direct pin-driven write_enable.

---
 rtl/lgn_seq_pkg.sv | 31 +++
 rtl/lgn_frame_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_lgn_frame_sequencer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/lgn_seq_pkg.sv
// ---------------------------------------------------------------------------
// lgn_seq_pkg
// Shared types and default constants for the lgn frame sequencer.
//   seq_state_e     : sequencer FSM states (LOAD, DRAIN, HOLD)
//   LGN_DATA_W      : default pixel byte width (lgn ui_in width)
//   LGN_OUT_W       : default lgn output word width
//   LGN_FRAME_BYTES : default bytes per frame (784 binarized pixels / 8)
//   cnt_width()     : byte counter width for a given frame length
// ---------------------------------------------------------------------------
package lgn_seq_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } seq_state_e;

  localparam int LGN_DATA_W      = 8;
  localparam int LGN_OUT_W       = 16;
  localparam int LGN_FRAME_BYTES = 98;

  // A one-byte frame still needs a 1-bit counter so the vector stays legal.
  function automatic int cnt_width(input int n_bytes);
    if (n_bytes > 1) begin
      return $clog2(n_bytes);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/lgn_frame_sequencer.sv
// ---------------------------------------------------------------------------
// lgn_frame_sequencer
// Sequences one classification frame into the logic-gate-network datapath:
// accepts BYTES_PER_FRAME bytes from a valid/ready source, issues one
// registered lgn write per byte, waits LGN_LATENCY cycles after the last
// write, captures lgn_out and presents it on a valid/ready result port.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   s_data/s_valid     pixel byte stream in
//   s_ready            high only in LOAD (combinational from state)
//   abort              single-cycle frame restart (ignored in HOLD)
//   lgn_data/lgn_we    registered byte and write strobe to lgn
//   lgn_out            lgn result word
//   res_data/res_valid captured result, held until res_ready
//   res_ready          result consumer ready
//   busy               high unless idle in LOAD with no bytes taken
//
// Optional build macro LGN_FRAME_SEQ_STATS_EN adds saturating counters:
//   frames_done (16 b) : result handshakes
//   aborts      (8 b)  : aborts that actually discarded work
// ---------------------------------------------------------------------------
module lgn_frame_sequencer
  import lgn_seq_pkg::*;
#(
  parameter int DATA_W          = LGN_DATA_W,
  parameter int OUT_W           = LGN_OUT_W,
  parameter int BYTES_PER_FRAME = LGN_FRAME_BYTES,
  parameter int LGN_LATENCY     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              abort,
  output logic [DATA_W-1:0] lgn_data,
  output logic              lgn_we,
  input  logic [OUT_W-1:0]  lgn_out,
  output logic [OUT_W-1:0]  res_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy
`ifdef LGN_FRAME_SEQ_STATS_EN
  ,
  output logic [15:0]       frames_done,
  output logic [7:0]        aborts
`endif
);

  localparam int                CNT_W    = cnt_width(BYTES_PER_FRAME);
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(BYTES_PER_FRAME - 1);
  localparam logic [7:0]        LAT_INIT = 8'(LGN_LATENCY);

  seq_state_e        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [7:0]        r_lat;
  logic              r_lgn_we;
  logic [DATA_W-1:0] r_lgn_data;
  logic              r_res_valid;
  logic [OUT_W-1:0]  r_res_data;

  seq_state_e        w_state;
  logic [CNT_W-1:0]  w_cnt;
  logic [7:0]        w_lat;
  logic              w_lgn_we;
  logic [DATA_W-1:0] w_lgn_data;
  logic              w_res_valid;
  logic [OUT_W-1:0]  w_res_data;
  logic              w_abort_hit;
  logic              w_frame_done;

  // Next-state and next-output logic for the LOAD/DRAIN/HOLD sequencer.
  always_comb begin
    w_state      = r_state;
    w_cnt        = r_cnt;
    w_lat        = r_lat;
    w_lgn_we     = 1'b0;
    w_lgn_data   = r_lgn_data;
    w_res_valid  = r_res_valid;
    w_res_data   = r_res_data;
    w_abort_hit  = 1'b0;
    w_frame_done = 1'b0;

    case (r_state)
      LOAD: begin
        if (abort) begin
          // abort beats s_valid: the same-cycle byte is dropped
          w_cnt       = {CNT_W{1'b0}};
          w_abort_hit = (r_cnt != {CNT_W{1'b0}}) || s_valid;
        end else if (s_valid) begin
          w_lgn_we   = 1'b1;
          w_lgn_data = s_data;
          if (r_cnt == LAST_IDX) begin
            w_cnt   = {CNT_W{1'b0}};
            w_lat   = LAT_INIT;
            w_state = DRAIN;
          end else begin
            w_cnt = r_cnt + CNT_W'(1);
          end
        end else begin
          w_cnt = r_cnt;
        end
      end

      DRAIN: begin
        if (abort) begin
          w_state     = LOAD;
          w_cnt       = {CNT_W{1'b0}};
          w_lat       = 8'd0;
          w_abort_hit = 1'b1;
        end else begin
          // lat was loaded in the cycle of the final lgn_we, so reaching 1
          // here means LGN_LATENCY cycles have elapsed since that write.
          w_lat = r_lat - 8'd1;
          if (r_lat == 8'd1) begin
            w_res_data  = lgn_out;
            w_res_valid = 1'b1;
            w_state     = HOLD;
          end else begin
            w_state = DRAIN;
          end
        end
      end

      HOLD: begin
        if (res_ready && r_res_valid) begin
          w_res_valid  = 1'b0;
          w_state      = LOAD;
          w_frame_done = 1'b1;
        end else begin
          w_state = HOLD;
        end
      end

      default: begin
        w_state     = LOAD;
        w_cnt       = {CNT_W{1'b0}};
        w_lat       = 8'd0;
        w_res_valid = 1'b0;
      end
    endcase
  end

  // State and output registers; rst outranks abort and everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= LOAD;
      r_cnt       <= {CNT_W{1'b0}};
      r_lat       <= 8'd0;
      r_lgn_we    <= 1'b0;
      r_lgn_data  <= {DATA_W{1'b0}};
      r_res_valid <= 1'b0;
      r_res_data  <= {OUT_W{1'b0}};
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_lat       <= w_lat;
      r_lgn_we    <= w_lgn_we;
      r_lgn_data  <= w_lgn_data;
      r_res_valid <= w_res_valid;
      r_res_data  <= w_res_data;
    end
  end

  assign s_ready   = (r_state == LOAD);
  assign busy      = !((r_state == LOAD) && (r_cnt == {CNT_W{1'b0}}));
  assign lgn_we    = r_lgn_we;
  assign lgn_data  = r_lgn_data;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;

`ifdef LGN_FRAME_SEQ_STATS_EN
  logic [15:0] r_frames_done;
  logic [7:0]  r_aborts;

  // Saturating frame and effective-abort counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frames_done <= 16'd0;
      r_aborts      <= 8'd0;
    end else begin
      if (w_frame_done && (r_frames_done != 16'hFFFF)) begin
        r_frames_done <= r_frames_done + 16'd1;
      end else begin
        r_frames_done <= r_frames_done;
      end
      if (w_abort_hit && (r_aborts != 8'hFF)) begin
        r_aborts <= r_aborts + 8'd1;
      end else begin
        r_aborts <= r_aborts;
      end
    end
  end

  assign frames_done = r_frames_done;
  assign aborts      = r_aborts;
`endif

endmodule

// File: tb/tb_lgn_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_lgn_frame_sequencer
// Randomized self-checking bench for lgn_frame_sequencer. A behavioural
// reference tracks frame progress in plain integers (bytes taken, absolute
// cycle at which the result is due) and is compared every cycle. A small
// lgn model latches the last written byte and answers {8'h5A, byte}.
// ---------------------------------------------------------------------------
module tb_lgn_frame_sequencer;

  localparam int DW  = 8;
  localparam int OW  = 16;
  localparam int BPF = 98;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_data = 8'h00;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          abort = 1'b0;
  logic [DW-1:0] lgn_data;
  logic          lgn_we;
  logic [OW-1:0] lgn_out;
  logic [OW-1:0] res_data;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic          busy;
`ifdef LGN_FRAME_SEQ_STATS_EN
  logic [15:0]   frames_done;
  logic [7:0]    aborts;
`endif

  always #5 clk = ~clk;

  lgn_frame_sequencer #(
    .DATA_W(DW), .OUT_W(OW), .BYTES_PER_FRAME(BPF), .LGN_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .abort(abort), .lgn_data(lgn_data), .lgn_we(lgn_we),
    .lgn_out(lgn_out), .res_data(res_data), .res_valid(res_valid),
    .res_ready(res_ready), .busy(busy)
`ifdef LGN_FRAME_SEQ_STATS_EN
    , .frames_done(frames_done), .aborts(aborts)
`endif
  );

  // lgn stand-in: keeps the most recently written byte (never reset)
  logic [7:0] lgn_mem = 8'h00;
  always @(posedge clk) if (lgn_we) lgn_mem <= lgn_data;
  assign lgn_out = {8'h5A, lgn_mem};

  // reference model: 0 = taking bytes, 1 = waiting for lgn, 2 = result held
  int          m_mode = 0;
  int          m_cnt = 0;
  longint      cyc = 0;
  longint      t_res = 0;
  logic [7:0]  m_last = 8'h00;
  logic [7:0]  m_lgn_data = 8'h00;
  logic        m_we = 1'b0;
  logic        m_resv = 1'b0;
  logic [15:0] m_resd = 16'h0000;
  int          m_frames = 0;
  int          m_aborts = 0;
  int          we_obs = 0;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // Drive one cycle, advance the reference, then compare all outputs.
  task automatic step(input logic v, input logic [7:0] d, input logic ab,
                      input logic rr, input logic rs);
    s_valid = v; s_data = d; abort = ab; res_ready = rr; rst = rs;
    m_we = 1'b0;
    if (rs) begin
      m_mode = 0; m_cnt = 0; m_lgn_data = 8'h00; m_resv = 1'b0;
      m_resd = 16'h0000; m_frames = 0; m_aborts = 0;
    end else begin
      case (m_mode)
        0: begin
          if (ab) begin
            if (m_cnt > 0 || v) m_aborts = (m_aborts < 255) ? m_aborts + 1 : 255;
            m_cnt = 0;
          end else if (v) begin
            m_we = 1'b1;
            m_lgn_data = d;
            m_cnt++;
            if (m_cnt == BPF) begin
              m_cnt = 0; m_mode = 1; m_last = d;
              t_res = cyc + 1 + LAT;
            end
          end
        end
        1: begin
          if (ab) begin
            m_mode = 0;
            m_aborts = (m_aborts < 255) ? m_aborts + 1 : 255;
          end else if (cyc + 1 == t_res) begin
            m_mode = 2; m_resv = 1'b1; m_resd = {8'h5A, m_last};
          end
        end
        default: begin
          if (rr) begin
            m_resv = 1'b0; m_mode = 0;
            m_frames = (m_frames < 65535) ? m_frames + 1 : 65535;
          end
        end
      endcase
    end
    @(posedge clk);
    cyc++;
    #1;
    if (lgn_we === 1'b1) we_obs++;
    check_val("lgn_we", {31'd0, lgn_we}, {31'd0, m_we});
    check_val("lgn_data", {24'd0, lgn_data}, {24'd0, m_lgn_data});
    check_val("res_valid", {31'd0, res_valid}, {31'd0, m_resv});
    check_val("res_data", {16'd0, res_data}, {16'd0, m_resd});
    check_val("s_ready", {31'd0, s_ready}, {31'd0, (m_mode == 0)});
    check_val("busy", {31'd0, busy}, {31'd0, !(m_mode == 0 && m_cnt == 0)});
`ifdef LGN_FRAME_SEQ_STATS_EN
    check_val("frames_done", {16'd0, frames_done}, m_frames);
    check_val("aborts", {24'd0, aborts}, m_aborts);
`endif
  endtask

  // Offer bytes at pct% density until nbytes are taken; seq gives 0,1,2,...
  task automatic send_frame(input int nbytes, input int pct, input bit seq,
                            output logic [7:0] last);
    int sent = 0;
    int guard = 0;
    logic v;
    logic [7:0] d;
    last = 8'h00;
    while (sent < nbytes && guard < 5000) begin
      v = ($urandom_range(0, 99) < pct);
      d = seq ? sent[7:0] : 8'($urandom);
      if (!v) d = 8'($urandom);
      if (v && m_mode == 0) begin
        sent++;
        last = d;
      end
      step(v, d, 1'b0, 1'b0, 1'b0);
      guard++;
    end
    if (sent < nbytes) check_val("send_timeout", sent, nbytes);
  endtask

  // Wait for the result, check latency and value, hold it, then release/reset.
  task automatic get_result(input logic [15:0] exp_res, input int hold, input bit rst_in_hold);
    int n = 0;
    while (res_valid !== 1'b1 && n < 300) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'b0, 1'($urandom_range(0, 1)), 1'b0);
      n++;
    end
    check_val("latency", n, LAT);
    check_val("frame_result", {16'd0, res_data}, {16'd0, exp_res});
    for (int i = 0; i < hold; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    check_val("held_result", {16'd0, res_data}, {16'd0, exp_res});
    if (rst_in_hold) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    else             step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  logic [7:0] lb;
  int we0;

  initial begin
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // nominal back-to-back frame 0x00..0x61, then 20 cycles of backpressure
    we0 = we_obs;
    send_frame(BPF, 100, 1'b1, lb);
    check_val("nominal_we_count", we_obs - we0, BPF);
    get_result(16'h5A61, 20, 1'b0);

    // gapped input at 30%, same byte sequence, then a random-data frame
    we0 = we_obs;
    send_frame(BPF, 30, 1'b1, lb);
    check_val("gapped_we_count", we_obs - we0, BPF);
    get_result(16'h5A61, 3, 1'b0);
    send_frame(BPF, 60, 1'b0, lb);
    get_result({8'h5A, lb}, 2, 1'b0);

    // abort after 40 bytes, then a full frame: one result, 138 writes
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    we0 = we_obs;
    send_frame(40, 100, 1'b0, lb);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    send_frame(BPF, 100, 1'b0, lb);
    get_result({8'h5A, lb}, 1, 1'b0);
    check_val("abort_we_total", we_obs - we0, 138);
`ifdef LGN_FRAME_SEQ_STATS_EN
    check_val("abort_count", {24'd0, aborts}, 1);
    check_val("frames_count", {16'd0, frames_done}, 1);
`endif

    // abort with s_valid at cnt=0, then abort during DRAIN
    step(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
    send_frame(BPF, 100, 1'b0, lb);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check_val("drain_abort_no_result", {31'd0, res_valid}, 0);
    send_frame(BPF, 80, 1'b0, lb);
    get_result({8'h5A, lb}, 2, 1'b0);

    // reset at byte 50, reset in HOLD, then a clean frame
    send_frame(50, 100, 1'b0, lb);
    step(1'b1, 8'h33, 1'b0, 1'b0, 1'b1);
    check_val("rst_mid_lgn_data", {24'd0, lgn_data}, 0);
    send_frame(BPF, 100, 1'b0, lb);
    get_result({8'h5A, lb}, 4, 1'b1);
    check_val("rst_hold_res_valid", {31'd0, res_valid}, 0);
    send_frame(BPF, 50, 1'b0, lb);
    get_result({8'h5A, lb}, 0, 1'b0);

    // random mix of everything
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 99) < 70, 8'($urandom), $urandom_range(0, 199) < 2,
           $urandom_range(0, 99) < 30, $urandom_range(0, 999) < 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
